// File: rtl/rv_m_pkg.sv
// Shared encodings for the RV M-extension coprocessor: funct3 opcodes and
// the top-level FSM state constants.
package rv_m_pkg;

  // M-extension funct3 encoding
  localparam logic [2:0] MUL    = 3'd0;
  localparam logic [2:0] MULH   = 3'd1;
  localparam logic [2:0] MULHSU = 3'd2;
  localparam logic [2:0] MULHU  = 3'd3;
  localparam logic [2:0] DIV    = 3'd4;
  localparam logic [2:0] DIVU   = 3'd5;
  localparam logic [2:0] REM    = 3'd6;
  localparam logic [2:0] REMU   = 3'd7;

  // Top-level FSM states
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/rv_m_iter_core.sv
// Iterative radix-2 engine: shift-add multiply and restoring divide on
// operand magnitudes, with sign fix-up applied to the final registers.
// 'done' is high in the cycle whose closing edge performs the last
// iteration; 'result' is valid from the following cycle until the next start.
module rv_m_iter_core
  import rv_m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            start,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      f3,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  // Multiply: acc = {partial sum, remaining multiplier bits}, opnd = |rs1|.
  // Divide:   acc = {partial remainder, dividend/quotient bits}, opnd = |rs2|.
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   opnd;
  logic [2:0]        f3_q;
  logic              neg_lo;
  logic              neg_hi;
  logic [CW-1:0]     cnt;
  logic              running;

  logic              sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_cat;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  // Operand signedness and magnitudes at start (MUL low half is sign-agnostic)
  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    if (f3[2]) begin
      sa = ~f3[0] & rs1[XLEN-1];
      sb = ~f3[0] & rs2[XLEN-1];
    end else begin
      sa = (f3 != MULHU) & rs1[XLEN-1];
      sb = ((f3 == MUL) || (f3 == MULH)) & rs2[XLEN-1];
    end
    a_mag = sa ? -rs1 : rs1;
    b_mag = sb ? -rs2 : rs2;
  end

  // One radix-2 step of either the shift-add or the restoring algorithm
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    div_cat  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = div_cat - {1'b0, opnd};
    if (f3_q[2]) begin
      if (div_diff[XLEN]) acc_next = {div_cat[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else                acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      if (acc[0]) acc_next = {mul_sum, acc[XLEN-1:1]};
      else        acc_next = {1'b0, acc[2*XLEN-1:1]};
    end
  end

  // Load on start, then iterate exactly XLEN times
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      f3_q    <= '0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      f3_q    <= f3;
      neg_lo  <= sa ^ sb;
      if (f3[2]) begin
        acc    <= {{XLEN{1'b0}}, a_mag};
        opnd   <= b_mag;
        neg_hi <= sa;
      end else begin
        acc    <= {{XLEN{1'b0}}, b_mag};
        opnd   <= a_mag;
        neg_hi <= 1'b0;
      end
    end else if (running) begin
      acc <= acc_next;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(XLEN-1)) running <= 1'b0;
    end
  end

  assign done = running && (cnt == CW'(XLEN-1));

  // Sign fix-up and result selection from the final registers
  always_comb begin
    prod = neg_lo ? -acc : acc;
    quo  = neg_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (f3_q)
      MUL:                   result = prod[XLEN-1:0];
      MULH, MULHSU, MULHU:   result = prod[2*XLEN-1:XLEN];
      DIV, DIVU:             result = quo;
      default:               result = rem;
    endcase
  end

endmodule

// File: rtl/rv_m_shared_unit.sv
// Shared RV M-extension coprocessor: round-robin arbitration over NCH
// request channels, IDLE/CALC/DONE sequencing, the divide special-case
// fast path and the level-request / one-cycle-ack handshake.
// Handshake: a channel holds i_req and operands until o_ack[ch] pulses;
// o_ack/o_res are registered out of DONE, so the ack cycle is an IDLE cycle
// and whatever i_req shows at its closing edge is taken as a new request.
module rv_m_shared_unit
  import rv_m_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NCH  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NCH-1:0]       i_req,
  input  logic [NCH*XLEN-1:0]  i_rs1,
  input  logic [NCH*XLEN-1:0]  i_rs2,
  input  logic [NCH*3-1:0]     i_f3,
  output logic [XLEN-1:0]      o_res,
  output logic [NCH-1:0]       o_ack,
  output logic                 o_busy
);

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t            state;
  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     grant_q;
  logic              fast_q;
  logic [XLEN-1:0]   fast_res;

  logic              any_req;
  logic [GW-1:0]     sel;
  logic              found;
  logic [XLEN-1:0]   sel_rs1, sel_rs2;
  logic [2:0]        sel_f3;
  logic              is_fast;
  logic [XLEN-1:0]   fast_val;
  logic              core_start;
  logic              core_done;
  logic [XLEN-1:0]   core_res;

  // Round-robin pick: first requester above last_grant, wrapping around
  always_comb begin
    any_req = |i_req;
    sel     = '0;
    found   = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      if (!found && i_req[(int'(last_grant) + i) % NCH]) begin
        found = 1'b1;
        sel   = GW'((int'(last_grant) + i) % NCH);
      end
    end
  end

  // Selected operands and divide special-case detection
  always_comb begin
    sel_rs1  = i_rs1[int'(sel)*XLEN +: XLEN];
    sel_rs2  = i_rs2[int'(sel)*XLEN +: XLEN];
    sel_f3   = i_f3[int'(sel)*3 +: 3];
    is_fast  = 1'b0;
    fast_val = '0;
    if (sel_f3[2]) begin
      if (sel_rs2 == '0) begin
        is_fast  = 1'b1;
        fast_val = sel_f3[1] ? sel_rs1 : {XLEN{1'b1}};
      end else if (!sel_f3[0] && (sel_rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (sel_rs2 == {XLEN{1'b1}})) begin
        is_fast  = 1'b1;
        fast_val = sel_f3[1] ? '0 : sel_rs1;
      end
    end
  end

  assign core_start = (state == IDLE) && any_req && !is_fast;

  rv_m_iter_core #(.XLEN(XLEN)) u_core (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .start  (core_start),
    .rs1    (sel_rs1),
    .rs2    (sel_rs2),
    .f3     (sel_f3),
    .done   (core_done),
    .result (core_res)
  );

  // FSM, grant bookkeeping and registered ack/result
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state      <= IDLE;
      o_ack      <= '0;
      o_res      <= '0;
      last_grant <= GW'(NCH-1);
      grant_q    <= '0;
      fast_q     <= 1'b0;
      fast_res   <= '0;
    end else begin
      o_ack <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_q  <= sel;
            fast_q   <= is_fast;
            fast_res <= fast_val;
            state    <= is_fast ? DONE : CALC;
          end
        end
        CALC: begin
          if (core_done) state <= DONE;
        end
        DONE: begin
          o_ack      <= NCH'(1) << grant_q;
          o_res      <= fast_q ? fast_res : core_res;
          last_grant <= grant_q;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_rv_m_shared_unit.sv
// Directed bench for rv_m_shared_unit (XLEN=32, NCH=2): table of single
// operations with hand-computed results and latencies, then arbitration,
// reset-during-CALC and result-hold sequences.
module tb_rv_m_shared_unit;

  localparam int XLEN = 32;
  localparam int NCH  = 2;
  localparam int LAT_NORM = XLEN + 1;
  localparam int LAT_FAST = 1;

  logic                clk;
  logic                rst;
  logic [NCH-1:0]      req;
  logic [NCH*XLEN-1:0] rs1_bus;
  logic [NCH*XLEN-1:0] rs2_bus;
  logic [NCH*3-1:0]    f3_bus;
  logic [XLEN-1:0]     res;
  logic [NCH-1:0]      ack;
  logic                busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [XLEN-1:0] exp_q[$];

  rv_m_shared_unit #(.XLEN(XLEN), .NCH(NCH)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_req  (req),
    .i_rs1  (rs1_bus),
    .i_rs2  (rs2_bus),
    .i_f3   (f3_bus),
    .o_res  (res),
    .o_ack  (ack),
    .o_busy (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drive(input int ch, input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    req[ch] = 1'b1;
    rs1_bus[ch*XLEN +: XLEN] = a;
    rs2_bus[ch*XLEN +: XLEN] = b;
    f3_bus[ch*3 +: 3] = f3;
  endtask

  // Wait for any ack, sampling 1ns after each edge; counts edges waited
  task automatic wait_ack(input string name, output int cyc, output logic busy_ok, output logic got);
    cyc = 0;
    busy_ok = 1'b1;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ack != '0) got = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no ack after %0d cycles, required an ack", name, cyc);
    end
  endtask

  // One operation on one channel: acceptance, latency, ack, result, busy
  task automatic run_op(input string name, input int ch, input logic [2:0] f3,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp, input int lat);
    int cyc;
    logic bok, got;
    logic [XLEN-1:0] e;
    @(negedge clk);
    drive(ch, f3, a, b);
    exp_q.push_back(exp);
    @(posedge clk);
    wait_ack(name, cyc, bok, got);
    e = exp_q.pop_front();
    if (got) begin
      check({name, "_ack"}, XLEN'(ack), XLEN'(NCH'(1) << ch));
      check({name, "_res"}, res, e);
      check({name, "_lat"}, XLEN'(cyc), XLEN'(lat));
      check({name, "_busy"}, XLEN'(bok), XLEN'(1));
    end
    req[ch] = 1'b0;
  endtask

  typedef struct {
    int              ch;
    logic [2:0]      f3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
    int              lat;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int cyc;
    logic bok, got;
    logic ack_seen;
    logic [XLEN-1:0] held;
    int exp_ch[$];

    rst = 1'b0;
    req = '0;
    rs1_bus = '0;
    rs2_bus = '0;
    f3_bus = '0;

    vecs[0]  = '{0, 3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, LAT_NORM};
    vecs[1]  = '{0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, LAT_NORM};
    vecs[2]  = '{1, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_NORM};
    vecs[3]  = '{0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_NORM};
    vecs[4]  = '{0, 3'd4, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, LAT_FAST};
    vecs[5]  = '{1, 3'd6, 32'h00000005, 32'h00000000, 32'h00000005, LAT_FAST};
    vecs[6]  = '{0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_FAST};
    vecs[7]  = '{0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_FAST};
    vecs[8]  = '{0, 3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, LAT_NORM};
    vecs[9]  = '{1, 3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, LAT_NORM};
    vecs[10] = '{0, 3'd5, 32'd100,      32'd7,        32'd14,       LAT_NORM};
    vecs[11] = '{0, 3'd7, 32'd100,      32'd7,        32'd2,        LAT_NORM};
    vecs[12] = '{1, 3'd5, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, LAT_FAST};
    vecs[13] = '{0, 3'd7, 32'h00000005, 32'h00000000, 32'h00000005, LAT_FAST};
    vecs[14] = '{0, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, LAT_NORM};
    vecs[15] = '{1, 3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_NORM};

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset_ack", XLEN'(ack), '0);
    check("reset_res", res, '0);
    check("reset_busy", XLEN'(busy), '0);

    // Table of single operations
    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].ch, vecs[i].f3, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].lat);
    end

    // o_res holds after the ack cycle
    held = res;
    repeat (3) @(posedge clk);
    #1;
    check("res_hold", res, 32'h00000000);
    check("res_hold_vs_ack", res, held);

    // Arbitration: simultaneous requests after reset, continuous contention
    do_reset();
    exp_ch = '{0, 1, 0, 1};
    @(negedge clk);
    drive(0, 3'd0, 32'd2, 32'd3);
    drive(1, 3'd0, 32'd5, 32'd5);
    for (int k = 0; k < 4; k++) begin
      int ec;
      wait_ack($sformatf("arb%0d", k), cyc, bok, got);
      ec = exp_ch.pop_front();
      if (got) begin
        check($sformatf("arb%0d_ack", k), XLEN'(ack), XLEN'(NCH'(1) << ec));
        check($sformatf("arb%0d_res", k), res, (ec == 0) ? 32'd6 : 32'd25);
      end
    end
    req = '0;

    // Reset while in CALC: no ack, busy drops, then a fresh op works
    @(negedge clk);
    drive(0, 3'd0, 32'd123, 32'd456);
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    check("mid_calc_busy", XLEN'(busy), 32'd1);
    rst = 1'b0;
    req = '0;
    @(posedge clk);
    #1;
    check("rst_calc_busy", XLEN'(busy), '0);
    check("rst_calc_ack", XLEN'(ack), '0);
    rst = 1'b1;
    ack_seen = 1'b0;
    for (int k = 0; k < XLEN + 4; k++) begin
      @(posedge clk);
      #1;
      if (ack != '0) ack_seen = 1'b1;
    end
    check("rst_calc_no_ack", XLEN'(ack_seen), '0);
    run_op("post_rst_mul", 0, 3'd0, 32'd3, 32'd4, 32'd12, LAT_NORM);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
